// File: rtl/dram_arbiter.sv
// Four-requester arbiter onto a dual-port RAM, two winners per cycle.
// Build with ARB_STATS_EN defined to get the write-conflict defer counter.
module dram_arbiter #(
  parameter int AW = 3,
  parameter int DW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      req_wr,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      rvalid,
  output logic [4*DW-1:0] rdata,
  output logic            en_a,
  output logic            wr_a,
  output logic [AW-1:0]   addr_a,
  output logic [DW-1:0]   wdata_a,
  output logic            en_b,
  output logic            wr_b,
  output logic [AW-1:0]   addr_b,
  output logic [DW-1:0]   wdata_b,
  input  logic [DW-1:0]   rdata_a,
  input  logic [DW-1:0]   rdata_b,
  output logic [7:0]      defer_cnt
);

  typedef enum logic {IDLE, ISSUE} port_st_t;

  port_st_t  st_a, st_b;
  logic [1:0] rr_ptr;
  logic [1:0] tag_a, tag_b;
  logic       rd_a_vld;
  logic [1:0] rd_a_tag;

  logic [3:0] elig;
  logic [1:0] idx;
  logic       first_vld, second_vld;
  logic [1:0] first, second;
  logic [AW-1:0] addr_f, addr_s;
  logic       conflict;
  logic       a_vld, b_vld;
  logic [3:0] gnt_nxt;
  logic [3:0] rv_nxt;
  logic [1:0] ptr_nxt;

  assign elig = req & ~gnt;

  // Rotating search: first winner from rr_ptr, second after it
  always_comb begin
    idx        = '0;
    first_vld  = 1'b0;
    first      = '0;
    second_vld = 1'b0;
    second     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!first_vld && elig[idx]) begin
        first_vld = 1'b1;
        first     = idx;
      end
    end
    for (int k = 1; k < 4; k++) begin
      idx = first + 2'(k);
      if (first_vld && !second_vld && elig[idx]) begin
        second_vld = 1'b1;
        second     = idx;
      end
    end
  end

  assign addr_f = req_addr[first*AW +: AW];
  assign addr_s = req_addr[second*AW +: AW];

  // Two writes to one address cannot share a cycle; B waits
  assign conflict = second_vld && req_wr[first]
                 && req_wr[second] && (addr_f == addr_s);

  assign a_vld = first_vld;
  assign b_vld = second_vld && !conflict;

  // Next grant vector, read-return vector and pointer
  always_comb begin
    gnt_nxt = '0;
    rv_nxt  = '0;
    ptr_nxt = rr_ptr;
    if (a_vld) begin
      gnt_nxt[first] = 1'b1;
      ptr_nxt        = first + 2'd1;
    end
    if (b_vld) begin
      gnt_nxt[second] = 1'b1;
      ptr_nxt         = second + 2'd1;
    end
    if (en_a && !wr_a) rv_nxt[tag_a] = 1'b1;
    if (en_b && !wr_b) rv_nxt[tag_b] = 1'b1;
  end

  assign en_a = (st_a == ISSUE);
  assign en_b = (st_b == ISSUE);

  // Port FSMs, command registers, grants and read-return tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_a     <= IDLE;
      st_b     <= IDLE;
      wr_a     <= 1'b0;
      wr_b     <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      wdata_a  <= '0;
      wdata_b  <= '0;
      tag_a    <= '0;
      tag_b    <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      rr_ptr   <= '0;
      rd_a_vld <= 1'b0;
      rd_a_tag <= '0;
    end else begin
      gnt      <= gnt_nxt;
      rvalid   <= rv_nxt;
      rr_ptr   <= ptr_nxt;
      rd_a_vld <= en_a && !wr_a;
      rd_a_tag <= tag_a;
      if (a_vld) begin
        st_a    <= ISSUE;
        wr_a    <= req_wr[first];
        addr_a  <= addr_f;
        wdata_a <= req_wdata[first*DW +: DW];
        tag_a   <= first;
      end else begin
        st_a    <= IDLE;
      end
      if (b_vld) begin
        st_b    <= ISSUE;
        wr_b    <= req_wr[second];
        addr_b  <= addr_s;
        wdata_b <= req_wdata[second*DW +: DW];
        tag_b   <= second;
      end else begin
        st_b    <= IDLE;
      end
    end
  end

  // Steer RAM read data to the requester slice, zero otherwise
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (rvalid[i]) begin
        if (rd_a_vld && rd_a_tag == 2'(i))
          rdata[i*DW +: DW] = rdata_a;
        else
          rdata[i*DW +: DW] = rdata_b;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [7:0] defer_q;

  // Saturating count of port-B deferrals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      defer_q <= '0;
    else if (conflict && defer_q != 8'hff)
      defer_q <= defer_q + 8'd1;
  end

  assign defer_cnt = defer_q;
`else
  assign defer_cnt = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed cases plus
// randomized traffic against a queue-based reference model.
module tb_dram_arbiter;
  localparam int AW = 3;
  localparam int DW = 3;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0]      req_wr;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]      gnt;
  logic [3:0]      rvalid;
  logic [4*DW-1:0] rdata;
  logic            en_a, wr_a, en_b, wr_b;
  logic [AW-1:0]   addr_a, addr_b;
  logic [DW-1:0]   wdata_a, wdata_b;
  logic [DW-1:0]   rdata_a = '0;
  logic [DW-1:0]   rdata_b = '0;
  logic [7:0]      defer_cnt;

  logic [DW-1:0] ram [8] = '{3'd0, 3'd6, 3'd1, 3'd5,
                             3'd2, 3'd3, 3'd7, 3'd4};

  int n_pass;
  int n_total;

  // reference model state
  logic [DW-1:0] m_mem [8] = '{3'd0, 3'd6, 3'd1, 3'd5,
                               3'd2, 3'd3, 3'd7, 3'd4};
  int            m_ptr;
  logic [3:0]    m_gnt;
  logic [3:0]    m_rv_pend;
  logic [4*DW-1:0] m_rd_pend;
  int            m_defer;

  // expectations for the cycle just after the latest edge
  logic [3:0]      exp_gnt;
  logic [3:0]      exp_rvalid;
  logic [4*DW-1:0] exp_rdata;
  logic            exp_en_a, exp_wr_a, exp_en_b, exp_wr_b;
  logic [AW-1:0]   exp_addr_a, exp_addr_b;
  logic [DW-1:0]   exp_wdata_a, exp_wdata_b;

  dram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .defer_cnt(defer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dual-port RAM, registered read, read-before-write
  always @(posedge clk) begin
    if (en_a) begin
      if (wr_a) ram[addr_a] <= wdata_a;
      else      rdata_a     <= ram[addr_a];
    end
    if (en_b) begin
      if (wr_b) ram[addr_b] <= wdata_b;
      else      rdata_b     <= ram[addr_b];
    end
  end

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_wr[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_gnt     = '0;
    m_rv_pend = '0;
    m_rd_pend = '0;
    m_defer   = 0;
  endtask

  // Predict the coming edge from the rules, then advance one clock
  task automatic step();
    int q[$];
    int a_i, b_i, w;
    logic [3:0] elig, ng, nrv;
    logic [4*DW-1:0] nrd;
    elig = req & ~m_gnt;
    for (int k = 0; k < 4; k++)
      if (elig[(m_ptr + k) % 4]) q.push_back((m_ptr + k) % 4);
    while (q.size() > 2) void'(q.pop_back());
    if (q.size() == 2) begin
      a_i = q[0];
      b_i = q[1];
      if (req_wr[a_i] && req_wr[b_i] &&
          req_addr[a_i*AW +: AW] == req_addr[b_i*AW +: AW]) begin
        void'(q.pop_back());
        if (m_defer < 255) m_defer++;
      end
    end
    ng = '0; nrv = '0; nrd = '0;
    foreach (q[j]) begin
      w = q[j];
      ng[w] = 1'b1;
      if (!req_wr[w]) begin
        nrv[w] = 1'b1;
        nrd[w*DW +: DW] = m_mem[req_addr[w*AW +: AW]];
      end
    end
    foreach (q[j]) begin
      w = q[j];
      if (req_wr[w]) m_mem[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
    end
    exp_en_a = q.size() > 0;
    exp_en_b = q.size() > 1;
    exp_wr_a = 1'b0; exp_addr_a = '0; exp_wdata_a = '0;
    exp_wr_b = 1'b0; exp_addr_b = '0; exp_wdata_b = '0;
    if (exp_en_a) begin
      w = q[0];
      exp_wr_a    = req_wr[w];
      exp_addr_a  = req_addr[w*AW +: AW];
      exp_wdata_a = req_wdata[w*DW +: DW];
    end
    if (exp_en_b) begin
      w = q[1];
      exp_wr_b    = req_wr[w];
      exp_addr_b  = req_addr[w*AW +: AW];
      exp_wdata_b = req_wdata[w*DW +: DW];
    end
    if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % 4;
    @(posedge clk);
    #1;
    exp_gnt    = ng;
    exp_rvalid = m_rv_pend;
    exp_rdata  = m_rd_pend;
    m_rv_pend  = nrv;
    m_rd_pend  = nrd;
    m_gnt      = ng;
  endtask

  task automatic do_reset();
    req = '0;
    req_wr = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    #3;
    n_total++;
    if ({gnt, rvalid} !== 8'h00)
      $display("FAIL reset_gnt_rvalid got %h exp 00", {gnt, rvalid});
    else n_pass++;
    n_total++;
    if ({en_a, en_b, wr_a, wr_b} !== 4'h0)
      $display("FAIL reset_en_wr got %b exp 0000", {en_a, en_b, wr_a, wr_b});
    else n_pass++;
    n_total++;
    if ({addr_a, addr_b, wdata_a, wdata_b} !== '0)
      $display("FAIL reset_cmd got %h exp 0", {addr_a, addr_b, wdata_a, wdata_b});
    else n_pass++;
    n_total++;
    if (defer_cnt !== 8'd0 || rdata !== '0)
      $display("FAIL reset_cnt_rdata got %0d/%h exp 0/0", defer_cnt, rdata);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(0, 1'b0, 3'd5, 3'd0);
    step();
    n_total++;
    if (gnt !== 4'b0001 || en_a !== 1'b1 || addr_a !== 3'd5 || en_b !== 1'b0)
      $display("FAIL single_grant got gnt=%b en_a=%b addr_a=%0d en_b=%b exp 0001 1 5 0",
               gnt, en_a, addr_a, en_b);
    else n_pass++;
    req = '0;
    step();
    n_total++;
    if (rvalid !== 4'b0001 || rdata[2:0] !== 3'd3)
      $display("FAIL single_rdata got rvalid=%b rdata0=%0d exp 0001 3",
               rvalid, rdata[2:0]);
    else n_pass++;
  endtask

  task automatic test_all_read();
    do_reset();
    set_req(0, 1'b0, 3'd1, 3'd0);
    set_req(1, 1'b0, 3'd2, 3'd0);
    set_req(2, 1'b0, 3'd5, 3'd0);
    set_req(3, 1'b0, 3'd6, 3'd0);
    step();
    n_total++;
    if (gnt !== 4'b0011)
      $display("FAIL all_read_g1 got %b exp 0011", gnt);
    else n_pass++;
    req[1:0] = 2'b00;
    step();
    n_total++;
    if (gnt !== 4'b1100 || rvalid !== 4'b0011 || rdata !== 12'o0016)
      $display("FAIL all_read_g2 got gnt=%b rv=%b rd=%o exp 1100 0011 0016",
               gnt, rvalid, rdata);
    else n_pass++;
    req = '0;
    step();
    n_total++;
    if (rvalid !== 4'b1100 || rdata !== exp_rdata || rdata !== 12'o7300)
      $display("FAIL all_read_rd got rv=%b rd=%o exp 1100 7300", rvalid, rdata);
    else n_pass++;
    req = 4'b1111;
    step();
    n_total++;
    if (gnt !== 4'b0011)
      $display("FAIL all_read_ptr_wrap got %b exp 0011", gnt);
    else n_pass++;
    req = '0;
    step();
  endtask

  task automatic test_write_conflict();
    do_reset();
    set_req(1, 1'b1, 3'd4, 3'd6);
    set_req(2, 1'b1, 3'd4, 3'd2);
    step();
    n_total++;
    if (gnt !== 4'b0010 || en_a !== 1'b1 || wr_a !== 1'b1 ||
        addr_a !== 3'd4 || wdata_a !== 3'd6 || en_b !== 1'b0)
      $display("FAIL conflict_c1 got gnt=%b a=%b%b/%0d/%0d en_b=%b exp 0010 11/4/6 0",
               gnt, en_a, wr_a, addr_a, wdata_a, en_b);
    else n_pass++;
    req[1] = 1'b0;
    step();
    n_total++;
    if (gnt !== 4'b0100 || en_a !== 1'b1 || wdata_a !== 3'd2 || rvalid !== 4'b0000)
      $display("FAIL conflict_c2 got gnt=%b en_a=%b wd=%0d rv=%b exp 0100 1 2 0000",
               gnt, en_a, wdata_a, rvalid);
    else n_pass++;
    req = '0;
    step();
    step();
    n_total++;
    if (ram[4] !== 3'd2)
      $display("FAIL conflict_ram got %0d exp 2", ram[4]);
    else n_pass++;
    n_total++;
`ifdef ARB_STATS_EN
    if (defer_cnt !== 8'd1)
      $display("FAIL conflict_defer got %0d exp 1", defer_cnt);
    else n_pass++;
`else
    if (defer_cnt !== 8'd0)
      $display("FAIL conflict_defer got %0d exp 0", defer_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_raw();
    do_reset();
    set_req(0, 1'b1, 3'd2, 3'd7);
    set_req(1, 1'b0, 3'd2, 3'd0);
    step();
    n_total++;
    if (gnt !== 4'b0011 || wr_a !== 1'b1 || en_b !== 1'b1 || wr_b !== 1'b0)
      $display("FAIL raw_grant got gnt=%b wr_a=%b en_b=%b wr_b=%b exp 0011 1 1 0",
               gnt, wr_a, en_b, wr_b);
    else n_pass++;
    req = '0;
    step();
    n_total++;
    if (rvalid !== 4'b0010 || rdata[5:3] !== 3'd1)
      $display("FAIL raw_rdata got rv=%b rd1=%0d exp 0010 1", rvalid, rdata[5:3]);
    else n_pass++;
    step();
    n_total++;
    if (ram[2] !== 3'd7)
      $display("FAIL raw_ram got %0d exp 7", ram[2]);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_req(0, 1'b0, 3'd5, 3'd0);
    step();
    n_total++;
    if (gnt !== 4'b0001)
      $display("FAIL inflight_grant got %b exp 0001", gnt);
    else n_pass++;
    req = '0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rvalid !== 4'b0000 || gnt !== 4'b0000 || en_a !== 1'b0)
      $display("FAIL inflight_async got rv=%b gnt=%b en_a=%b exp 0", rvalid, gnt, en_a);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if ({gnt, rvalid, en_a, en_b, wr_a, wr_b} !== '0 || rdata !== '0 ||
          {addr_a, addr_b, wdata_a, wdata_b} !== '0)
        $display("FAIL inflight_quiet c%0d got gnt=%b rv=%b en=%b%b rd=%h exp 0",
                 c, gnt, rvalid, en_a, en_b, rdata);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 3)), DW'($urandom));
      step();
      for (int i = 0; i < 4; i++)
        if (exp_gnt[i]) req[i] = 1'b0;
      n_total++;
      if (gnt !== exp_gnt || $countones(gnt) > 2)
        $display("FAIL rnd_gnt c%0d got %b exp %b", c, gnt, exp_gnt);
      else n_pass++;
      n_total++;
      if (rvalid !== exp_rvalid || rdata !== exp_rdata)
        $display("FAIL rnd_read c%0d got %b/%h exp %b/%h",
                 c, rvalid, rdata, exp_rvalid, exp_rdata);
      else n_pass++;
      n_total++;
      if (en_a !== exp_en_a || en_b !== exp_en_b)
        $display("FAIL rnd_en c%0d got %b%b exp %b%b",
                 c, en_a, en_b, exp_en_a, exp_en_b);
      else n_pass++;
      if (exp_en_a) begin
        n_total++;
        if (wr_a !== exp_wr_a || addr_a !== exp_addr_a ||
            (exp_wr_a && wdata_a !== exp_wdata_a))
          $display("FAIL rnd_port_a c%0d got %b/%0d/%0d exp %b/%0d/%0d",
                   c, wr_a, addr_a, wdata_a, exp_wr_a, exp_addr_a, exp_wdata_a);
        else n_pass++;
      end
      if (exp_en_b) begin
        n_total++;
        if (wr_b !== exp_wr_b || addr_b !== exp_addr_b ||
            (exp_wr_b && wdata_b !== exp_wdata_b))
          $display("FAIL rnd_port_b c%0d got %b/%0d/%0d exp %b/%0d/%0d",
                   c, wr_b, addr_b, wdata_b, exp_wr_b, exp_addr_b, exp_wdata_b);
        else n_pass++;
      end
      n_total++;
`ifdef ARB_STATS_EN
      if (defer_cnt !== 8'(m_defer))
        $display("FAIL rnd_defer c%0d got %0d exp %0d", c, defer_cnt, m_defer);
      else n_pass++;
`else
      if (defer_cnt !== 8'd0)
        $display("FAIL rnd_defer c%0d got %0d exp 0", c, defer_cnt);
      else n_pass++;
`endif
    end
    req = '0;
    step();
    step();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    model_reset();
    test_reset();
    test_single_read();
    test_all_read();
    test_write_conflict();
    test_raw();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
